mux_sel_pipe: RTL

- Parametrised N-channel, W-bit registered selector for the ULA datapath.
- Accepts a packed vector of channel words per transaction and emits through a valid/ready output register.
- Direct mode emits the one channel named by sel.
- Scan mode emits every channel in ascending order, one beat per handshake, and marks the final beat.

---
 rtl/mux_sel_pipe.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mux_sel_pipe.sv
// N-channel registered selector with valid/ready output: direct mode emits one channel,
// scan mode emits every channel in ascending order. Optional per-channel scan mask: MUX_SCAN_MASK_EN.
module mux_sel_pipe #(
  parameter int WIDTH = 4,
  parameter int NCH   = 8,
  parameter int SELW  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*WIDTH-1:0]  in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SELW-1:0]       sel,
  input  logic                  mode,
`ifdef MUX_SCAN_MASK_EN
  input  logic [NCH-1:0]        scan_mask,
`endif
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_ch,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]           state_r, nxt_state_s;
  logic [SELW-1:0]      idx_r, nxt_idx_s;
  logic [NCH*WIDTH-1:0] buf_r;
  logic [NCH-1:0]       mask_r, mask_in_s;
  logic [WIDTH-1:0]     out_data_r, ld_data_s;
  logic [SELW-1:0]      out_ch_r, ld_ch_s;
  logic                 out_last_r, ld_last_s;
  logic                 out_valid_r, ld_valid_s;
  logic                 free_s, hs_s, cap_s;
  logic [SELW:0]        first_s, next_s;

`ifdef MUX_SCAN_MASK_EN
  assign mask_in_s = scan_mask;
`else
  assign mask_in_s = {NCH{1'b1}};
`endif

  // Word of channel k; indices beyond the channel count read as zero.
  function automatic logic [WIDTH-1:0] chan_of(input logic [NCH*WIDTH-1:0] data,
                                               input logic [SELW-1:0] k);
    logic [WIDTH-1:0] r;
    r = {WIDTH{1'b0}};
    for (int j = 0; j < NCH; j++) begin
      if (int'(k) == j) begin
        r = data[j*WIDTH +: WIDTH];
      end
    end
    return r;
  endfunction

  // Lowest enabled channel at or above start; MSB flags whether one was found.
  function automatic logic [SELW:0] first_from(input logic [NCH-1:0] mask, input int start);
    logic [SELW:0] r;
    r = {(SELW+1){1'b0}};
    for (int k = 0; k < NCH; k++) begin
      if (!r[SELW] && (k >= start) && mask[k]) begin
        r = {1'b1, SELW'(k)};
      end
    end
    return r;
  endfunction

  assign free_s   = !out_valid_r || out_ready;
  assign in_ready = (state_r == ST_IDLE) && free_s;
  assign hs_s     = in_valid && in_ready;

  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;
  assign out_last  = out_last_r;
  assign out_valid = out_valid_r;

  // Next-beat selection and FSM transition.
  always_comb begin
    ld_valid_s  = 1'b0;
    ld_data_s   = {WIDTH{1'b0}};
    ld_ch_s     = {SELW{1'b0}};
    ld_last_s   = 1'b0;
    nxt_state_s = state_r;
    nxt_idx_s   = idx_r;
    cap_s       = 1'b0;
    first_s     = {(SELW+1){1'b0}};
    next_s      = {(SELW+1){1'b0}};
    if (hs_s) begin
      if (!mode) begin
        ld_valid_s = 1'b1;
        ld_data_s  = chan_of(in_data, sel);
        ld_ch_s    = sel;
        ld_last_s  = 1'b1;
      end else begin
        cap_s   = 1'b1;
        first_s = first_from(mask_in_s, 0);
        if (first_s[SELW]) begin
          ld_valid_s = 1'b1;
          ld_data_s  = chan_of(in_data, first_s[SELW-1:0]);
          ld_ch_s    = first_s[SELW-1:0];
          next_s     = first_from(mask_in_s, int'(first_s[SELW-1:0]) + 1);
          if (next_s[SELW]) begin
            ld_last_s   = 1'b0;
            nxt_state_s = ST_SCAN;
            nxt_idx_s   = next_s[SELW-1:0];
          end else begin
            ld_last_s   = 1'b1;
          end
        end else begin
          // Empty mask: the transaction is consumed without a beat.
          ld_valid_s = 1'b0;
        end
      end
    end else if ((state_r == ST_SCAN) && free_s) begin
      ld_valid_s = 1'b1;
      ld_data_s  = chan_of(buf_r, idx_r);
      ld_ch_s    = idx_r;
      next_s     = first_from(mask_r, int'(idx_r) + 1);
      if (next_s[SELW]) begin
        ld_last_s = 1'b0;
        nxt_idx_s = next_s[SELW-1:0];
      end else begin
        ld_last_s   = 1'b1;
        nxt_state_s = ST_IDLE;
      end
    end else begin
      ld_valid_s = 1'b0;
    end
  end

  // Output register, FSM state and scan buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_ch_r    <= {SELW{1'b0}};
      out_last_r  <= 1'b0;
      state_r     <= ST_IDLE;
      idx_r       <= {SELW{1'b0}};
      buf_r       <= {(NCH*WIDTH){1'b0}};
      mask_r      <= {NCH{1'b0}};
    end else begin
      if (free_s) begin
        out_valid_r <= ld_valid_s;
        if (ld_valid_s) begin
          out_data_r <= ld_data_s;
          out_ch_r   <= ld_ch_s;
          out_last_r <= ld_last_s;
        end
      end
      state_r <= nxt_state_s;
      idx_r   <= nxt_idx_s;
      if (cap_s) begin
        buf_r  <= in_data;
        mask_r <= mask_in_s;
      end
    end
  end

endmodule
